// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S clocking slice: rate codes, sequencer states
// and frame geometry.
package i2s_pkg;

    localparam logic [1:0] RATE_48K  = 2'd0;
    localparam logic [1:0] RATE_96K  = 2'd1;
    localparam logic [1:0] RATE_192K = 2'd2;

    localparam int FRAME_BITS = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_HOLD,
        ST_SETTLE,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous strobe, with a third flop that
// turns a high-to-low transition into a single-cycle pulse.
module sync_edge_det (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic fall_o
);

    // [0] and [1] form the synchronizer, [2] is the previous synchronized value.
    logic [2:0] shift_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_q <= '0;
        end else begin
            shift_q <= {shift_q[1:0], async_i};
        end
    end

    assign fall_o = shift_q[2] & ~shift_q[1];

endmodule

// File: rtl/i2s_rate_sequencer.sv
// Applies sample-rate changes to the I2S clock generator glitch-free: waits for
// a frame boundary, holds the generator in reset while s_rate changes, then
// waits one full frame before unmuting.
module i2s_rate_sequencer
    import i2s_pkg::*;
#(
    parameter int         HOLD_CYCLES    = 4,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [1:0] RESET_RATE     = 2'd0
) (
    input  logic       SAICLK,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_rate,
    output logic       req_ready,
    input  logic       LRCLK,
    output logic       clkgen_reset_n,
    output logic [1:0] s_rate,
    output logic       mute,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 10) ? $clog2(TIMEOUT_CYCLES) : 10;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       pend_rate_q;
    logic [1:0]       s_rate_q;
    logic             clkgen_reset_n_q;
    logic             mute_q;
    logic             busy_q;
    logic             done_q;
    logic             req_ready_q;
    logic             timeout_err_q;
    logic             lr_fall;

    sync_edge_det u_lr_sync (
        .clk_i   (SAICLK),
        .reset_i (reset),
        .async_i (LRCLK),
        .fall_o  (lr_fall)
    );

    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Reset lands in HOLD so power-up runs the same release-and-settle path as a
    // requested change; every state entry restarts the counter.
    always_ff @(posedge SAICLK) begin
        if (reset) begin
            state_q          <= ST_HOLD;
            cnt_q            <= '0;
            pend_rate_q      <= RESET_RATE;
            s_rate_q         <= RESET_RATE;
            clkgen_reset_n_q <= 1'b0;
            mute_q           <= 1'b1;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            req_ready_q      <= 1'b0;
            timeout_err_q    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        pend_rate_q   <= req_rate;
                        timeout_err_q <= 1'b0;
                        cnt_q         <= '0;
                        req_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        if (req_rate == s_rate_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT_FRAME;
                            mute_q  <= 1'b1;
                        end
                    end
                end
                ST_WAIT_FRAME: begin
                    if (lr_fall || cnt_q == TO_LAST) begin
                        if (!lr_fall) begin
                            timeout_err_q <= 1'b1;
                        end
                        state_q          <= ST_HOLD;
                        cnt_q            <= '0;
                        clkgen_reset_n_q <= 1'b0;
                        s_rate_q         <= pend_rate_q;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q          <= ST_SETTLE;
                        cnt_q            <= '0;
                        clkgen_reset_n_q <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (lr_fall || cnt_q == TO_LAST) begin
                        if (!lr_fall) begin
                            timeout_err_q <= 1'b1;
                        end
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    mute_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    mute_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign clkgen_reset_n = clkgen_reset_n_q;
    assign s_rate         = s_rate_q;
    assign mute           = mute_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_i2s_rate_sequencer.sv
// Directed bench for i2s_rate_sequencer driving a behavioural model of the
// I2S clock generator (BCLK half-period = div+1 SAICLK, 64-BCLK frames).
module tb_i2s_rate_sequencer;
    import i2s_pkg::*;

    logic       SAICLK = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_rate;
    logic       req_ready;
    logic       LRCLK;
    logic       clkgen_reset_n;
    logic [1:0] s_rate;
    logic       mute;
    logic       busy;
    logic       done;
    logic       timeout_err;

    int checkCount = 0;
    int passCount  = 0;

    i2s_rate_sequencer #(
        .HOLD_CYCLES    (4),
        .TIMEOUT_CYCLES (1024),
        .RESET_RATE     (RATE_48K)
    ) dut (
        .SAICLK         (SAICLK),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_rate       (req_rate),
        .req_ready      (req_ready),
        .LRCLK          (LRCLK),
        .clkgen_reset_n (clkgen_reset_n),
        .s_rate         (s_rate),
        .mute           (mute),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err)
    );

    always #5 SAICLK = ~SAICLK;

    // Clock generator model: LRCLK is low for the first half of each frame and
    // falls when the 128th BCLK half-period completes.
    logic [1:0] genHalf = 2'd0;
    logic [6:0] genBits = 7'd0;
    logic       lrTieLow = 1'b0;
    logic       genLr;
    logic       genBclk;

    function automatic logic [1:0] divOf(input logic [1:0] rate);
        if (rate == RATE_48K) return 2'd2;
        if (rate == RATE_96K) return 2'd1;
        return 2'd0;
    endfunction

    always @(posedge SAICLK) begin
        if (!clkgen_reset_n) begin
            genHalf <= 2'd0;
            genBits <= 7'd0;
        end else if (genHalf == divOf(s_rate)) begin
            genHalf <= 2'd0;
            genBits <= genBits + 7'd1;
        end else begin
            genHalf <= genHalf + 2'd1;
        end
    end

    assign genLr   = genBits[6];
    assign genBclk = genBits[0];
    assign LRCLK   = lrTieLow ? 1'b0 : genLr;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Measurements gathered by watchSeq for the sequence in progress.
    int cyc = 0;
    int wPre, wHold, wSettle, wLrHigh, wBclkPer, wFallToHold;
    int wSrateHold, wSrateRelease, wTerrAtHold, wDoneSeen;

    task automatic watchSeq(input int budget, input bit injectReq);
        bit sawHold = 0;
        bit sawRelease = 0;
        bit lrPrev = LRCLK;
        bit bclkPrev = 1'b0;
        int lastFall = -1000;
        int lastRise = -1;
        wPre = 0; wHold = 0; wSettle = 0; wLrHigh = 0; wBclkPer = 0;
        wFallToHold = -1; wSrateHold = -1; wSrateRelease = -1;
        wTerrAtHold = -1; wDoneSeen = 0;
        for (int i = 0; i < budget; i++) begin
            if (!LRCLK && lrPrev) lastFall = cyc;
            lrPrev = LRCLK;
            if (!clkgen_reset_n) begin
                if (!sawHold) begin
                    sawHold     = 1;
                    wFallToHold = cyc - lastFall;
                    wSrateHold  = s_rate;
                    wTerrAtHold = timeout_err;
                end
                wHold++;
            end else if (busy && !done) begin
                if (sawHold) begin
                    if (!sawRelease) begin
                        sawRelease    = 1;
                        wSrateRelease = s_rate;
                    end
                    wSettle++;
                end else begin
                    wPre++;
                end
            end
            if (sawRelease && clkgen_reset_n) begin
                if (LRCLK) wLrHigh++;
                if (genBclk && !bclkPrev) begin
                    if (lastRise >= 0 && wBclkPer == 0) wBclkPer = cyc - lastRise;
                    lastRise = cyc;
                end
                bclkPrev = genBclk;
            end
            if (injectReq && sawRelease) begin
                if (wSettle == 10) begin
                    req_valid = 1'b1;
                    req_rate  = RATE_48K;
                end
                if (wSettle == 12) checkOutput("ignored_req_ready", req_ready, 0);
                if (wSettle == 14) req_valid = 1'b0;
            end
            if (done) begin
                wDoneSeen = 1;
                break;
            end
            @(posedge SAICLK);
            #1;
            cyc++;
        end
        checkOutput("done_seen", wDoneSeen, 1);
    endtask

    task automatic applyStimulus(input logic [1:0] rate);
        int gotReady = 0;
        for (int i = 0; i < 2000; i++) begin
            if (req_ready) begin
                gotReady = 1;
                break;
            end
            @(posedge SAICLK);
            #1;
            cyc++;
        end
        checkOutput("ready_wait", gotReady, 1);
        req_valid = 1'b1;
        req_rate  = rate;
        @(posedge SAICLK);
        #1;
        cyc++;
        req_valid = 1'b0;
    endtask

    // One cycle after done: back in IDLE and unmuted.
    task automatic checkIdle(input string tag, input int expRate, input int expTerr);
        @(posedge SAICLK);
        #1;
        cyc++;
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_mute"}, mute, 0);
        checkOutput({tag, "_ready"}, req_ready, 1);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_rate"}, s_rate, expRate);
        checkOutput({tag, "_terr"}, timeout_err, expTerr);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int abortDone;
        int sawLow;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_rate  = 2'd0;
        repeat (5) @(posedge SAICLK);
        #1;
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_mute", mute, 1);
        checkOutput("rst_clkgen_n", clkgen_reset_n, 0);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_terr", timeout_err, 0);
        checkOutput("rst_rate", s_rate, RATE_48K);

        // Startup: HOLD -> SETTLE (one 48k frame + sync latency) -> DONE
        reset = 1'b0;
        watchSeq(3000, 0);
        checkOutput("start_hold", wHold, 4);
        checkOutput("start_settle", wSettle, 384 + 3);
        checkOutput("start_lr_high", wLrHigh, FRAME_BITS * 3);
        checkOutput("start_bclk_per", wBclkPer, 6);
        checkIdle("start_idle", RATE_48K, 0);

        // 48k -> 192k
        applyStimulus(RATE_192K);
        checkOutput("r2_busy", busy, 1);
        checkOutput("r2_mute", mute, 1);
        watchSeq(3000, 0);
        checkOutput("r2_fall_to_hold", wFallToHold, 3);
        checkOutput("r2_hold", wHold, 4);
        checkOutput("r2_rate_hold", wSrateHold, RATE_192K);
        checkOutput("r2_rate_release", wSrateRelease, RATE_192K);
        checkOutput("r2_bclk_per", wBclkPer, 2);
        checkOutput("r2_lr_high", wLrHigh, FRAME_BITS);
        checkOutput("r2_settle", wSettle, 128 + 3);
        checkIdle("r2_idle", RATE_192K, 0);

        // Generator disconnected: both waits time out
        lrTieLow = 1'b1;
        applyStimulus(RATE_96K);
        watchSeq(4000, 0);
        checkOutput("to_wait", wPre, 1024);
        checkOutput("to_terr_hold", wTerrAtHold, 1);
        checkOutput("to_hold", wHold, 4);
        checkOutput("to_settle", wSettle, 1024);
        checkOutput("to_done_terr", timeout_err, 1);
        checkIdle("to_idle", RATE_96K, 1);
        lrTieLow = 1'b0;

        // Same rate: immediate done, no mute, no generator reset; clears timeout_err
        applyStimulus(RATE_96K);
        checkOutput("same_done", done, 1);
        checkOutput("same_mute", mute, 0);
        checkOutput("same_clkgen_n", clkgen_reset_n, 1);
        checkOutput("same_terr", timeout_err, 0);
        checkOutput("same_busy", busy, 1);
        checkIdle("same_idle", RATE_96K, 0);

        // 96k -> 48k
        applyStimulus(RATE_48K);
        watchSeq(3000, 0);
        checkOutput("r0_fall_to_hold", wFallToHold, 3);
        checkOutput("r0_rate_hold", wSrateHold, RATE_48K);
        checkOutput("r0_settle", wSettle, 384 + 3);
        checkIdle("r0_idle", RATE_48K, 0);

        // 48k -> 96k with a stray request during SETTLE
        applyStimulus(RATE_96K);
        watchSeq(3000, 1);
        checkOutput("r1_settle", wSettle, 256 + 3);
        checkOutput("r1_rate_release", wSrateRelease, RATE_96K);
        checkIdle("r1_idle", RATE_96K, 0);
        repeat (3) begin
            @(posedge SAICLK);
            #1;
            cyc++;
        end
        checkOutput("r1_no_extra_busy", busy, 0);
        checkOutput("r1_final_rate", s_rate, RATE_96K);

        // 96k -> 192k aborted by reset in the middle of HOLD
        applyStimulus(RATE_192K);
        sawLow = 0;
        abortDone = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done) abortDone++;
            if (!clkgen_reset_n) begin
                sawLow = 1;
                break;
            end
            @(posedge SAICLK);
            #1;
            cyc++;
        end
        checkOutput("abort_hold_seen", sawLow, 1);
        @(posedge SAICLK);
        #1;
        cyc++;
        if (done) abortDone++;
        checkOutput("abort_rate_mid", s_rate, RATE_192K);
        reset = 1'b1;
        @(posedge SAICLK);
        #1;
        cyc++;
        if (done) abortDone++;
        checkOutput("abort_rate_rst", s_rate, RATE_48K);
        checkOutput("abort_clkgen_n", clkgen_reset_n, 0);
        checkOutput("abort_mute", mute, 1);
        reset = 1'b0;
        watchSeq(3000, 0);
        checkOutput("abort_no_done", abortDone, 0);
        checkOutput("abort_hold", wHold, 4);
        checkOutput("abort_settle", wSettle, 384 + 3);
        checkIdle("abort_idle", RATE_48K, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
